bp_be_late_scoreboard: RTL and testbench
========================================

# bp_be_late_scoreboard

Parametrised late-writeback scoreboard for the BE checker. It is the successor to the single-score/single-clear, 1-bit-per-register scoreboard. It tracks up to 2^cnt_width_p-1 outstanding late writes per architectural register, with configurable score, clear and lookup port counts. It also provides flush, back-pressure, empty and underflow reporting. Two instances sit in the detector, one for the integer file and one for the FP file; their match outputs feed the RAW/WAW hazard logic that gates dispatch.

## Interface
Parameters:
- num_regs_p, 32, architectural registers tracked; addr width aw = $clog2(num_regs_p)
- num_rs_p, 3, source lookup ports
- num_score_p, 2, score (allocate) ports; lower index has priority
- num_clear_p, 2, clear (writeback) ports
- cnt_width_p, 2, per-register pending counter width; max = 2^cnt_width_p-1
- zero_reg_hardwired_p, 1, 1 = register 0 is never scored and never matches (integer file); 0 = register 0 is tracked normally (FP file)

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all pending entries
- score_v_i  in  num_score_p  score request per port
- score_rd_i  in  num_score_p*aw  destination register per score port
- score_ready_o  out  num_score_p  score port accepted this cycle
- clear_v_i  in  num_clear_p  late writeback valid per port
- clear_rd_i  in  num_clear_p*aw  written register per clear port
- rs_i  in  num_rs_p*aw  source registers of the instruction in issue
- rd_i  in  aw  destination register of the instruction in issue
- rs_match_o  out  num_rs_p  source has a pending late write
- rd_match_o  out  1  destination has a pending late write (WAW)
- empty_o  out  1  registered; no register has a pending write
- underflow_o  out  1  sticky; a clear hit a zero counter

## Operation
- State: cnt[r], cnt_width_p bits, for each register r; reset value 0.
- Score acceptance for port k: score_ready_o[k] = score_v_i[k] & ~flush_i & ~(zero_reg_hardwired_p & score_rd==0) & (cnt[rd_k] + n_prior < max).
  - n_prior is the number of accepted ports j<k with the same rd.
  - Ready is computed from registered cnt only. Same-cycle clears do not free space.
- Clear effect: for each valid clear port targeting r, cnt[r] is decremented.
  - A clear to r with cnt[r]==0 (counting earlier same-cycle clears to r) is dropped and sets underflow_o.
  - A clear to r0 is ignored when zero_reg_hardwired_p=1.
- Next count: cnt_n[r] = cnt[r] + accepted_scores(r) - effective_clears(r). Widths are sized to avoid overflow. The result is always in 0..max.
- Simultaneous score and clear on the same r: net change, e.g. 1 + 1 - 1 = 1.
- Flush: if flush_i, all cnt_n = 0 regardless of scores and clears, and no score is accepted. underflow_o is unaffected by flush.
- Lookups:
  - rs_match_o[i] = (cnt[rs_i[i]] != 0) & ~(zero_reg_hardwired_p & rs_i[i]==0).
  - rd_match_o is defined the same way using rd_i.
  - Lookups are pure combinational reads of registered state, with no bypass of same-cycle score or clear.
- empty_o is registered and equals (all cnt_n == 0), updated every cycle.
- underflow_o is sticky. Only reset clears it.
- Index ≥ num_regs_p on any address port: behaviour is unspecified. Assertion-checked in simulation.

## Timing
- Reset (asynchronous, reset_n_i low): all cnt = 0, empty_o = 1, underflow_o = 0. Consequently rs_match_o = 0 and rd_match_o = 0. Reset takes effect immediately, mid-operation included, and discards everything in flight.
- score_ready_o: combinational, same cycle as score_v_i. The upstream dispatch stage must treat a non-ready score as a stall.
- Score accepted in cycle t: rs_match_o and rd_match_o reflect it in t+1; empty_o deasserts in t+1.
- Clear in cycle t: match deasserts in t+1 if the count reaches 0; empty_o asserts in t+1 if every counter is 0.
- Flush in cycle t: all matches 0 and empty_o = 1 in t+1.
- Saturation: with cnt[r]==max, a score to r is refused (score_ready_o = 0) even if a clear to r occurs in the same cycle.

## Test plan
- Reset/basic: after reset, empty_o=1. Score rd=5 at t, then rs_i[0]=5 -> rs_match_o[0]=1 at t+1 and empty_o=0. Clear rd=5 at t+3 -> rs_match_o[0]=0 and empty_o=1 at t+4.
- Multi-outstanding: cnt_width_p=2, three scores to rd=7 on consecutive cycles, then a fourth -> score_ready_o=0. Clear ×3 -> match drops only after the third clear.
- Dual port same cycle: score ports 0 and 1 both rd=9 with cnt[9]=2 -> port 0 ready, port 1 not, cnt=3. Both clear ports rd=9 next cycle -> cnt=1, match still 1.
- Simultaneous score+clear rd=4 with cnt=1 -> cnt stays 1, rs_match_o stays 1, underflow_o=0.
- Zero register: zero_reg_hardwired_p=1, score rd=0 -> score_ready_o=0, rs_i=0 never matches, empty_o stays 1. With zero_reg_hardwired_p=0, r0 is tracked like any register.
- Flush/underflow/async reset:
  - Flush with 5 registers pending plus a concurrent score -> all matches 0, empty_o=1 next cycle.
  - Clear rd=3 while cnt[3]=0 -> underflow_o=1, held until reset.
  - reset_n_i pulsed mid-cycle -> outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/bp_be_late_scoreboard.sv
// bp_be_late_scoreboard
//   Late-writeback scoreboard. It keeps one pending-write counter per
//   architectural register. Score ports allocate entries, and clear ports
//   retire them. Lookup ports report which registers still have a late
//   write outstanding, so the hazard logic can hold dispatch.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   flush_i                 drop every pending entry; no score is taken
//   score_v_i/score_rd_i    allocate requests (lower port index wins)
//   score_ready_o           per-port acceptance, combinational
//   clear_v_i/clear_rd_i    late writebacks
//   rs_i/rs_match_o         source lookups against registered counts
//   rd_i/rd_match_o         destination lookup (WAW)
//   empty_o                 registered: no counter is non-zero
//   underflow_o             sticky: a clear found its counter already at 0
//
// Score handshake: an entry is allocated exactly when score_v_i[k] and
// score_ready_o[k] are both high in the same cycle. score_ready_o[k] may
// depend on score_v_i. A valid score that is not ready is not allocated,
// and the requester must stall and re-present it.
module bp_be_late_scoreboard #(
  parameter int num_regs_p           = 32,
  parameter int num_rs_p             = 3,
  parameter int num_score_p          = 2,
  parameter int num_clear_p          = 2,
  parameter int cnt_width_p          = 2,
  parameter int zero_reg_hardwired_p = 1,
  localparam int aw = $clog2(num_regs_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic [num_score_p-1:0]      score_v_i,
  input  logic [num_score_p*aw-1:0]   score_rd_i,
  output logic [num_score_p-1:0]      score_ready_o,
  input  logic [num_clear_p-1:0]      clear_v_i,
  input  logic [num_clear_p*aw-1:0]   clear_rd_i,
  input  logic [num_rs_p*aw-1:0]      rs_i,
  input  logic [aw-1:0]               rd_i,
  output logic [num_rs_p-1:0]         rs_match_o,
  output logic                        rd_match_o,
  output logic                        empty_o,
  output logic                        underflow_o
);

  localparam int max_cnt = (1 << cnt_width_p) - 1;
  // Wide enough for count plus every score port, with one spare bit.
  localparam int cw = cnt_width_p + $clog2(num_score_p + num_clear_p + 1) + 1;
  localparam bit zero_hw = (zero_reg_hardwired_p != 0);

  logic [cnt_width_p-1:0] cnt   [num_regs_p];
  logic [cnt_width_p-1:0] cnt_n [num_regs_p];

  logic [aw-1:0] s_rd [num_score_p];
  logic [aw-1:0] c_rd [num_clear_p];
  logic [aw-1:0] l_rs [num_rs_p];

  for (genvar k = 0; k < num_score_p; k++) begin : g_srd
    assign s_rd[k] = score_rd_i[k*aw +: aw];
  end
  for (genvar p = 0; p < num_clear_p; p++) begin : g_crd
    assign c_rd[p] = clear_rd_i[p*aw +: aw];
  end
  for (genvar i = 0; i < num_rs_p; i++) begin : g_rs
    assign l_rs[i] = rs_i[i*aw +: aw];
  end

  // Score acceptance: uses registered counts only, so a clear in the
  // same cycle never frees room for a score.
  logic [cw-1:0] n_prior;
  always_comb begin
    score_ready_o = '0;
    n_prior       = '0;
    for (int k = 0; k < num_score_p; k++) begin
      n_prior = '0;
      for (int j = 0; j < k; j++) begin
        if (score_ready_o[j] && (s_rd[j] == s_rd[k])) n_prior = n_prior + 1'b1;
      end
      score_ready_o[k] = score_v_i[k] && !flush_i
                         && !(zero_hw && (s_rd[k] == '0))
                         && ((cw'(cnt[s_rd[k]]) + n_prior) < cw'(max_cnt));
    end
  end

  // Clear effectiveness: a clear counts only if the counter still holds
  // an entry after the earlier effective clears to the same register.
  logic [num_clear_p-1:0] clr_eff;
  logic [cw-1:0]          c_prior;
  logic                   uf_set;
  always_comb begin
    clr_eff = '0;
    c_prior = '0;
    uf_set  = 1'b0;
    for (int p = 0; p < num_clear_p; p++) begin
      c_prior = '0;
      for (int q = 0; q < p; q++) begin
        if (clr_eff[q] && (c_rd[q] == c_rd[p])) c_prior = c_prior + 1'b1;
      end
      if (clear_v_i[p] && !(zero_hw && (c_rd[p] == '0))) begin
        if (cw'(cnt[c_rd[p]]) > c_prior) clr_eff[p] = 1'b1;
        else                             uf_set     = 1'b1;
      end
    end
  end

  // Next counts: add accepted scores, then subtract effective clears.
  // The sum stays within 0..max_cnt because effective clears never
  // exceed the registered count.
  logic [cw-1:0] acc;
  logic          empty_n;
  always_comb begin
    acc     = '0;
    empty_n = 1'b1;
    for (int r = 0; r < num_regs_p; r++) begin
      acc = cw'(cnt[r]);
      for (int k = 0; k < num_score_p; k++) begin
        if (score_ready_o[k] && (s_rd[k] == aw'(r))) acc = acc + 1'b1;
      end
      for (int p = 0; p < num_clear_p; p++) begin
        if (clr_eff[p] && (c_rd[p] == aw'(r))) acc = acc - 1'b1;
      end
      cnt_n[r] = flush_i ? '0 : acc[cnt_width_p-1:0];
      if (cnt_n[r] != '0) empty_n = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < num_regs_p; r++) cnt[r] <= '0;
      empty_o     <= 1'b1;
      underflow_o <= 1'b0;
    end else begin
      for (int r = 0; r < num_regs_p; r++) cnt[r] <= cnt_n[r];
      empty_o <= empty_n;
      if (uf_set) underflow_o <= 1'b1;
    end
  end

  // Lookups read registered state only, with no same-cycle bypass.
  always_comb begin
    rs_match_o = '0;
    for (int i = 0; i < num_rs_p; i++) begin
      rs_match_o[i] = (cnt[l_rs[i]] != '0) && !(zero_hw && (l_rs[i] == '0));
    end
    rd_match_o = (cnt[rd_i] != '0) && !(zero_hw && (rd_i == '0));
  end

  // Address range checks on every address port.
  always_comb begin
    if (reset_n_i) begin
      for (int k = 0; k < num_score_p; k++)
        assert ({1'b0, s_rd[k]} < (aw+1)'(num_regs_p));
      for (int p = 0; p < num_clear_p; p++)
        assert ({1'b0, c_rd[p]} < (aw+1)'(num_regs_p));
      for (int i = 0; i < num_rs_p; i++)
        assert ({1'b0, l_rs[i]} < (aw+1)'(num_regs_p));
      assert ({1'b0, rd_i} < (aw+1)'(num_regs_p));
    end
  end

endmodule

// File: tb/tb_bp_be_late_scoreboard.sv
// Testbench for bp_be_late_scoreboard. It drives two instances with the
// same inputs: an integer-file instance (r0 hardwired) and an FP-file
// instance (r0 tracked).
//
// Check vector bit layout:
//   [1:0] score_ready  [4:2] rs_match  [5] rd_match  [6] empty
//   [7] underflow      [8] fp rs_match[0]  [9] fp empty
module tb_bp_be_late_scoreboard;

  localparam int AW = 5;
  localparam int W  = 10;

  localparam logic [W-1:0] M_RDY = 10'h003;
  localparam logic [W-1:0] M_RS  = 10'h01C;
  localparam logic [W-1:0] M_RD  = 10'h020;
  localparam logic [W-1:0] M_EMP = 10'h040;
  localparam logic [W-1:0] M_UF  = 10'h080;
  localparam logic [W-1:0] M_FP  = 10'h300;
  localparam logic [W-1:0] M_ALL = 10'h3FF;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          flush;
  logic [1:0]    score_v;
  logic [2*AW-1:0] score_rd;
  logic [1:0]    clear_v;
  logic [2*AW-1:0] clear_rd;
  logic [3*AW-1:0] rs;
  logic [AW-1:0] rd;

  logic [1:0] score_ready, fp_score_ready;
  logic [2:0] rs_match, fp_rs_match;
  logic       rd_match, fp_rd_match;
  logic       empty, fp_empty;
  logic       underflow, fp_underflow;

  bp_be_late_scoreboard #(.zero_reg_hardwired_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .score_v_i(score_v), .score_rd_i(score_rd), .score_ready_o(score_ready),
    .clear_v_i(clear_v), .clear_rd_i(clear_rd),
    .rs_i(rs), .rd_i(rd),
    .rs_match_o(rs_match), .rd_match_o(rd_match),
    .empty_o(empty), .underflow_o(underflow)
  );

  bp_be_late_scoreboard #(.zero_reg_hardwired_p(0)) dut_fp (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .score_v_i(score_v), .score_rd_i(score_rd), .score_ready_o(fp_score_ready),
    .clear_v_i(clear_v), .clear_rd_i(clear_rd),
    .rs_i(rs), .rd_i(rd),
    .rs_match_o(fp_rs_match), .rd_match_o(fp_rd_match),
    .empty_o(fp_empty), .underflow_o(fp_underflow)
  );

  // Scoreboard state.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int n_compared = 0;
  int n_mismatch = 0;

  function automatic logic [W-1:0] ev(input logic [1:0] rdy, input logic [2:0] rsm,
                                      input logic rdm, input logic emp, input logic uf,
                                      input logic fprs, input logic fpemp);
    return {fpemp, fprs, uf, emp, rdm, rsm, rdy};
  endfunction

  // Driver tasks.
  task automatic idle();
    flush = 1'b0; score_v = '0; score_rd = '0;
    clear_v = '0; clear_rd = '0; rs = '0; rd = '0;
  endtask

  task automatic sc(input int p, input int r);
    score_v[p] = 1'b1;
    score_rd[p*AW +: AW] = AW'(r);
  endtask

  task automatic cl(input int p, input int r);
    clear_v[p] = 1'b1;
    clear_rd[p*AW +: AW] = AW'(r);
  endtask

  task automatic set_rs(input int i, input int r);
    rs[i*AW +: AW] = AW'(r);
  endtask

  task automatic set_rd(input int r);
    rd = AW'(r);
  endtask

  task automatic push(input string name, input logic [W-1:0] e, input logic [W-1:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(name);
  endtask

  // Called just after a rising edge. The inputs set before the call are
  // held for one cycle, and the monitor checks this cycle at the falling edge.
  task automatic step(input string name, input logic [W-1:0] e, input logic [W-1:0] m);
    push(name, e, m);
    @(posedge clk); #1;
    idle();
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  logic [W-1:0] act;
  assign act = {fp_empty, fp_rs_match[0], underflow, empty, rd_match, rs_match, score_ready};

  initial begin
    logic [W-1:0] e, m;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        m  = mask_q.pop_front();
        nm = name_q.pop_front();
        if (m != '0) begin
          n_compared++;
          if (((act ^ e) & m) != '0) begin
            n_mismatch++;
            $display("FAIL %s: actual=%b required=%b (mask %b)", nm, act & m, e & m, m);
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    reset_n = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset state.
    step("reset_hold", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_ALL);
    reset_n = 1'b1;
    step("post_reset", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_ALL);

    // Basic score, lookup and clear on r5.
    sc(0, 5);
    step("t1_score", ev(2'b01, 3'b000, 0, 1, 0, 0, 0), M_RDY | M_EMP);
    set_rs(0, 5);
    step("t1_match", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RS | M_EMP);
    cl(0, 5); set_rs(0, 5);
    step("t1_clear", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RS | M_EMP);
    set_rs(0, 5);
    step("t1_cleared", ev(2'b00, 3'b000, 0, 1, 0, 0, 0), M_RS | M_EMP | M_UF);

    // Multiple outstanding writes to r7 and saturation.
    sc(0, 7);
    step("t2_s1", ev(2'b01, 3'b000, 0, 0, 0, 0, 0), M_RDY);
    sc(0, 7); set_rs(0, 7);
    step("t2_s2", ev(2'b01, 3'b001, 0, 0, 0, 0, 0), M_RDY | M_RS);
    sc(0, 7);
    step("t2_s3", ev(2'b01, 3'b000, 0, 0, 0, 0, 0), M_RDY);
    sc(0, 7); cl(0, 7); set_rs(0, 7);
    step("t2_sat", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RDY | M_RS);
    cl(0, 7); set_rs(0, 7);
    step("t2_c2", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RS);
    cl(0, 7); set_rs(0, 7);
    step("t2_c3", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RS);
    set_rs(0, 7);
    step("t2_done", ev(2'b00, 3'b000, 0, 1, 0, 0, 0), M_RS | M_EMP);

    // Both score ports on r9 in one cycle, then port priority near the limit.
    sc(0, 9); sc(1, 9);
    step("t3_both", ev(2'b11, 3'b000, 0, 1, 0, 0, 0), M_RDY | M_EMP);
    sc(0, 9); sc(1, 9); set_rd(9);
    step("t3_prio", ev(2'b01, 3'b000, 1, 0, 0, 0, 0), M_RDY | M_RD);
    cl(0, 9); cl(1, 9); set_rs(2, 9);
    step("t3_dclr", ev(2'b00, 3'b100, 0, 0, 0, 0, 0), M_RS);
    set_rs(2, 9); set_rd(9); cl(0, 9);
    step("t3_left", ev(2'b00, 3'b100, 1, 0, 0, 0, 0), M_RS | M_RD | M_EMP);

    // Simultaneous score and clear on r4.
    sc(0, 4);
    step("t4_s", ev(2'b01, 3'b000, 0, 1, 0, 0, 0), M_RDY | M_EMP);
    sc(0, 4); cl(0, 4); set_rs(1, 4);
    step("t4_sc", ev(2'b01, 3'b010, 0, 0, 0, 0, 0), M_RDY | M_RS);
    set_rs(1, 4);
    step("t4_hold", ev(2'b00, 3'b010, 0, 0, 0, 0, 0), M_RS | M_EMP | M_UF);
    cl(1, 4);
    step("t4_clr", ev(2'b00, 3'b000, 0, 0, 0, 0, 0), M_UF);

    // Register 0: hardwired in the integer instance, tracked in the FP one.
    sc(0, 0);
    step("t5_s0", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_RDY | M_EMP | M_FP);
    step("t5_look", ev(2'b00, 3'b000, 0, 1, 0, 1, 0), M_RS | M_RD | M_EMP | M_FP);
    cl(0, 0);
    step("t5_clr0", ev(2'b00, 3'b000, 0, 1, 0, 1, 0), M_UF | M_EMP | M_FP);
    step("t5_after", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_UF | M_EMP | M_FP);

    // Flush with five registers pending and a concurrent score.
    sc(0, 10); sc(1, 11);
    step("t6_a", ev(2'b11, 3'b000, 0, 1, 0, 0, 0), M_RDY);
    sc(0, 12); sc(1, 13);
    step("t6_b", ev(2'b11, 3'b000, 0, 0, 0, 0, 0), M_RDY | M_EMP);
    sc(0, 14);
    step("t6_c", ev(2'b01, 3'b000, 0, 0, 0, 0, 0), M_RDY);
    flush = 1'b1; sc(0, 15);
    set_rs(0, 10); set_rs(1, 12); set_rs(2, 14); set_rd(13);
    step("t6_flush", ev(2'b00, 3'b111, 1, 0, 0, 0, 0), M_RDY | M_RS | M_RD | M_EMP);
    set_rs(0, 10); set_rs(1, 12); set_rs(2, 14); set_rd(15);
    step("t6_after", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_RS | M_RD | M_EMP | M_UF | M_FP);

    // Underflow: two same-cycle clears to r9 with one entry pending.
    sc(0, 9);
    step("t7_s", ev(2'b01, 3'b000, 0, 1, 0, 0, 0), M_RDY | M_EMP);
    cl(0, 9); cl(1, 9); set_rs(0, 9);
    step("t7_dclr", ev(2'b00, 3'b001, 0, 0, 0, 0, 0), M_RS | M_UF | M_EMP);
    set_rs(0, 9);
    step("t7_uf", ev(2'b00, 3'b000, 0, 1, 1, 0, 0), M_RS | M_EMP | M_UF);
    flush = 1'b1;
    step("t7_flush", ev(2'b00, 3'b000, 0, 1, 1, 0, 0), M_UF);
    step("t7_hold", ev(2'b00, 3'b000, 0, 1, 1, 0, 0), M_UF | M_EMP);

    // Asynchronous reset in the middle of a cycle.
    sc(0, 20);
    step("t8_s", ev(2'b01, 3'b000, 0, 1, 1, 0, 0), M_RDY | M_UF);
    set_rs(0, 20);
    step("t8_pre", ev(2'b00, 3'b001, 0, 0, 1, 0, 0), M_RS | M_UF | M_EMP);
    set_rs(0, 20); set_rd(20);
    #1 reset_n = 1'b0;
    push("t8_async", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_RS | M_RD | M_EMP | M_UF | M_FP);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    idle();
    set_rs(0, 20);
    step("t8_post", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_RS | M_EMP | M_UF | M_FP);
    cl(0, 3);
    step("t8_clr3", ev(2'b00, 3'b000, 0, 1, 0, 0, 1), M_UF | M_EMP);
    step("t8_uf3", ev(2'b00, 3'b000, 0, 1, 1, 0, 1), M_UF | M_EMP);
    step("t8_sticky", ev(2'b00, 3'b000, 0, 1, 1, 0, 1), M_UF);

    // Final report.
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatch++;
      $display("FAIL queue_drain: actual=%0d left required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
